// File: rtl/fib_engine.sv
// rtl/fib_engine.sv - parametrised Fibonacci engine with start/busy/done handshake
//
// Purpose: computes fib(n) with fib(0)=fib(1)=1 for an N_W-bit index into a
// RES_W-bit result. Overflow is sticky over a run and reported with the result.
// Build option: FIB_SAT_EN - when defined, the running sum saturates to all-ones
// on the first carry-out; when undefined, the sum wraps modulo 2^RES_W.
//
// Ports:
//   clk    - rising-edge clock
//   CLR    - asynchronous active-high reset
//   start  - run request, sampled only in IDLE
//   n      - index, latched on the accepting edge
//   result - last completed fib(n), held until the next completion
//   busy   - high from the accepting edge until completion
//   done   - one-cycle completion pulse
//   ovf    - an addition of the last run carried out of RES_W bits
module fib_engine #(
    parameter int N_W   = 3,
    parameter int RES_W = 5
) (
    input  logic             clk,
    input  logic             CLR,
    input  logic             start,
    input  logic [N_W-1:0]   n,
    output logic [RES_W-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    typedef enum logic {IDLE, CALC} state_t;

    state_t           r_state;
    logic [RES_W-1:0] r_a;
    logic [RES_W-1:0] r_b;
    logic [N_W-1:0]   r_cnt;
    logic             r_ovf;
    logic [RES_W-1:0] r_result;
    logic             r_busy;
    logic             r_done;
    logic             r_ovf_out;

    // One extra bit holds the carry-out of the RES_W-bit add.
    logic [RES_W:0]   w_sum;
    logic             w_carry;

    assign w_sum   = {1'b0, r_a} + {1'b0, r_b};
    assign w_carry = w_sum[RES_W];

    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_result  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ovf_out <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= RES_W'(1);
                        r_b     <= RES_W'(1);
                        r_cnt   <= n;
                        r_ovf   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    if (r_cnt <= N_W'(1)) begin
                        r_result  <= r_b;
                        r_ovf_out <= r_ovf;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= IDLE;
                    end else begin
                        r_a   <= r_b;
                        r_cnt <= r_cnt - N_W'(1);
                        r_ovf <= r_ovf | w_carry;
`ifdef FIB_SAT_EN
                        // Once any carry has occurred the run stays pinned at all-ones.
                        if (w_carry || r_ovf)
                            r_b <= '1;
                        else
                            r_b <= w_sum[RES_W-1:0];
`else
                        r_b <= w_sum[RES_W-1:0];
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign result = r_result;
    assign busy   = r_busy;
    assign done   = r_done;
    assign ovf    = r_ovf_out;

endmodule

// File: tb/tb_fib_engine.sv
// tb/tb_fib_engine.sv - scoreboard bench for fib_engine with a reference model
module tb_fib_engine;

    localparam int N_W   = 4;
    localparam int RES_W = 5;

    logic             clk = 1'b0;
    logic             CLR = 1'b1;
    logic             start = 1'b0;
    logic [N_W-1:0]   n = '0;
    logic [RES_W-1:0] result;
    logic             busy;
    logic             done;
    logic             ovf;

    fib_engine #(.N_W(N_W), .RES_W(RES_W)) dut (
        .clk    (clk),
        .CLR    (CLR),
        .start  (start),
        .n      (n),
        .result (result),
        .busy   (busy),
        .done   (done),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int  n_v;
        int  res;
        int  ov;
        int  done_cyc;
        int  busy_len;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   free_edge = 0;

    task automatic check(input string nm, input longint act, input longint req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference: true Fibonacci value, then apply wrap or saturation.
    function automatic exp_t model(input int nn);
        exp_t   e;
        longint f0 = 1, f1 = 1, f;
        f = 1;
        for (int k = 2; k <= nn; k++) begin
            f  = f0 + f1;
            f0 = f1;
            f1 = f;
        end
        e.n_v = nn;
        e.ov  = (f >= (64'd1 << RES_W)) ? 1 : 0;
`ifdef FIB_SAT_EN
        e.res = e.ov ? ((1 << RES_W) - 1) : int'(f);
`else
        e.res = int'(f % (64'd1 << RES_W));
`endif
        e.busy_len = ((nn > 1) ? nn : 1);
        e.done_cyc = 0;
        return e;
    endfunction

    // Drive one cycle of inputs; a request is accepted when the engine is idle
    // at the coming edge, and the expected completion is queued at that point.
    task automatic drive(input logic s, input int nv);
        exp_t e;
        int   lat;
        @(negedge clk);
        start = s;
        n     = N_W'(nv);
        if (s && (cyc + 1 >= free_edge)) begin
            e          = model(nv);
            lat        = e.busy_len + 1;
            e.done_cyc = cyc + lat;
            free_edge  = cyc + 1 + lat;
            exp_q.push_back(e);
        end
    endtask

    task automatic run_one(input int nv);
        drive(1'b1, nv);
        while (cyc + 2 < free_edge) drive(1'b0, 0);
        drive(1'b0, 0);
    endtask

    // Monitor: checks every completion against the queue head and that the
    // outputs stay put between completions.
    initial begin
        int               busy_cnt = 0;
        logic [RES_W-1:0] last_res = '0;
        logic             last_ovf = 1'b0;
        exp_t             e;
        forever begin
            @(negedge clk);
            if (CLR) begin
                busy_cnt = 0;
                last_res = '0;
                last_ovf = 1'b0;
            end else if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("result_n%0d", e.n_v), result, e.res);
                    check($sformatf("ovf_n%0d", e.n_v), ovf, e.ov);
                    check($sformatf("done_cycle_n%0d", e.n_v), cyc, e.done_cyc);
                    check($sformatf("busy_len_n%0d", e.n_v), busy_cnt, e.busy_len);
                    check("busy_low_at_done", busy, 0);
                end
                busy_cnt = 0;
                last_res = result;
                last_ovf = ovf;
            end else begin
                if (busy) busy_cnt++;
                if (result !== last_res || ovf !== last_ovf)
                    check("output_stable", {ovf, result}, {last_ovf, last_res});
            end
        end
    end

    initial begin
        int budget;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_result", result, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_ovf", ovf, 0);
        #2 CLR = 1'b0;
        free_edge = 0;

        // Sweep n = 0..7
        for (int i = 0; i < 8; i++) run_one(i);

        // Held start with a mid-run dip: back-to-back runs of n=5
        for (int i = 0; i < 20; i++) drive(i != 3, 5);
        while (cyc + 2 < free_edge) drive(1'b0, 5);
        drive(1'b0, 0);

        // n is latched on the accepting edge only
        drive(1'b1, 6);
        drive(1'b0, 2);
        while (cyc + 2 < free_edge) drive(1'b0, 2);
        drive(1'b0, 0);

        // Overflow boundaries, then a clean run clears ovf
        run_one(8);
        run_one(9);
        run_one(3);
        run_one(15);
        run_one(1);

        // Abort with CLR at cycle 4 of an n=7 run
        drive(1'b1, 7);
        repeat (3) drive(1'b0, 0);
        @(negedge clk);
        check("abort_busy_before", busy, 1);
        #2 CLR = 1'b1;
        exp_q.delete();
        #1;
        check("abort_result", result, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_ovf", ovf, 0);
        @(negedge clk);
        #2 CLR = 1'b0;
        free_edge = 0;
        run_one(4);

        // Randomised traffic
        repeat (400) drive($urandom_range(0, 2) != 0, int'($urandom_range(0, (1 << N_W) - 1)));
        drive(1'b0, 0);

        budget = 100;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
